// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port cache-to-memory arbiter.
package mem_arbiter_pkg;

  // Default line / memory transfer width in bits.
  localparam int MEMORY_WIDTH = 64;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Requester port indices.
  localparam logic PORT_I = 1'b0;  // instruction cache
  localparam logic PORT_D = 1'b1;  // data cache

  // Memory operation encoding (matches mem_we).
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way picker: round-robin when fair=1, fixed priority
// to port 1 when fair=0. 'last' is the port that was granted most recently.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fair,
  output logic [1:0] grant,
  output logic       valid
);

  // Pick one requester; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    valid = |req;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (fair) grant = last ? 2'b01 : 2'b10;
        else      grant = 2'b10;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises the write-back and line-fill channels of the instruction cache
// (port 0) and data cache (port 1) onto one memory req/ack channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; evaluate candidates, grant one per cycle
// ST_BUSY | mem_req held with fixed we/addr/wdata until mem_ack
// ST_RESP | port ack high this cycle only; no grant evaluation
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = MEMORY_WIDTH,
  parameter int FAIR  = 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             p0_write_req,
  input  logic [31:0]      p0_write_addr,
  input  logic [WIDTH-1:0] p0_write_data,
  output logic             p0_write_ack,
  input  logic             p0_read_req,
  input  logic [31:0]      p0_read_addr,
  output logic [WIDTH-1:0] p0_read_data,
  output logic             p0_read_ack,

  input  logic             p1_write_req,
  input  logic [31:0]      p1_write_addr,
  input  logic [WIDTH-1:0] p1_write_data,
  output logic             p1_write_ack,
  input  logic             p1_read_req,
  input  logic [31:0]      p1_read_addr,
  output logic [WIDTH-1:0] p1_read_data,
  output logic             p1_read_ack,

  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic FAIR_EN = (FAIR != 0);

  logic [1:0]       state;
  logic             gnt_port;
  logic             gnt_op;
  logic             last_port;

  logic [1:0]       arb_req;
  logic [1:0]       arb_grant;
  logic             arb_valid;

  logic             sel_port;
  logic             sel_op;
  logic [31:0]      sel_addr;
  logic [WIDTH-1:0] sel_wdata;

  assign arb_req = {p1_write_req | p1_read_req, p0_write_req | p0_read_req};

  rr_arb2 u_rr_arb2 (
    .req   (arb_req),
    .last  (last_port),
    .fair  (FAIR_EN),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Request mux: the granted port's write beats its read so evictions
  // complete before the matching fill.
  always_comb begin
    sel_port  = (arb_grant == 2'b10) ? PORT_D : PORT_I;
    sel_op    = OP_RD;
    sel_addr  = '0;
    sel_wdata = '0;
    if (sel_port == PORT_D) begin
      if (p1_write_req) begin
        sel_op    = OP_WR;
        sel_addr  = p1_write_addr;
        sel_wdata = p1_write_data;
      end else begin
        sel_addr  = p1_read_addr;
      end
    end else begin
      if (p0_write_req) begin
        sel_op    = OP_WR;
        sel_addr  = p0_write_addr;
        sel_wdata = p0_write_data;
      end else begin
        sel_addr  = p0_read_addr;
      end
    end
  end

  // Main FSM with memory-side datapath and response demux.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      gnt_port     <= PORT_I;
      gnt_op       <= OP_RD;
      last_port    <= PORT_D;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_write_ack <= 1'b0;
      p0_read_ack  <= 1'b0;
      p0_read_data <= '0;
      p1_write_ack <= 1'b0;
      p1_read_ack  <= 1'b0;
      p1_read_data <= '0;
    end else begin
      p0_write_ack <= 1'b0;
      p0_read_ack  <= 1'b0;
      p1_write_ack <= 1'b0;
      p1_read_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_port  <= sel_port;
            gnt_op    <= sel_op;
            mem_req   <= 1'b1;
            mem_we    <= sel_op;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            last_port <= gnt_port;
            state     <= ST_RESP;
            if (gnt_port == PORT_D) begin
              if (gnt_op == OP_WR) begin
                p1_write_ack <= 1'b1;
              end else begin
                p1_read_ack  <= 1'b1;
                p1_read_data <= mem_rdata;
              end
            end else begin
              if (gnt_op == OP_WR) begin
                p0_write_ack <= 1'b1;
              end else begin
                p0_read_ack  <= 1'b1;
                p0_read_data <= mem_rdata;
              end
            end
          end
        end
        // Requesters drop req during the ack; returning to IDLE without
        // evaluating keeps a stale req from being re-granted.
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory
// transactions and port acks; monitors pop and compare when the DUT shows them.
module tb_mem_arbiter;

  localparam int W = 64;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [W-1:0]  wdata;
  } mem_exp_t;

  typedef struct {
    int            port;
    logic          op;
    logic [W-1:0]  data;
  } ack_exp_t;

  logic clk;
  logic reset;

  logic         p0_write_req, p0_read_req, p1_write_req, p1_read_req;
  logic [31:0]  p0_write_addr, p0_read_addr, p1_write_addr, p1_read_addr;
  logic [W-1:0] p0_write_data, p1_write_data;
  logic         p0_write_ack, p0_read_ack, p1_write_ack, p1_read_ack;
  logic [W-1:0] p0_read_data, p1_read_data;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [W-1:0] mem_wdata, mem_rdata;

  // Second instance with FAIR=0, read-only traffic.
  logic         f_p0_rreq, f_p1_rreq, f_mem_ack;
  logic [W-1:0] f_mem_rdata;
  logic         f_p0_wack, f_p0_rack, f_p1_wack, f_p1_rack;
  logic [W-1:0] f_p0_rdata, f_p1_rdata, f_mem_wdata;
  logic         f_mem_req, f_mem_we;
  logic [31:0]  f_mem_addr;

  int tests = 0;
  int fails = 0;
  int mem_txn = 0;
  int rearm0 = 0, rearm1 = 0, rearm_f1 = 0;
  bit pend0 = 0, pend1 = 0, pend_f1 = 0;
  bit mem_auto = 1;
  int mem_lat = 2;

  mem_exp_t exp_mem[$];
  ack_exp_t exp_ack[$];
  logic [31:0] exp_faddr[$];
  ack_exp_t exp_fack[$];

  mem_arbiter #(.WIDTH(W), .FAIR(1)) dut (
    .clk(clk), .reset(reset),
    .p0_write_req(p0_write_req), .p0_write_addr(p0_write_addr), .p0_write_data(p0_write_data),
    .p0_write_ack(p0_write_ack), .p0_read_req(p0_read_req), .p0_read_addr(p0_read_addr),
    .p0_read_data(p0_read_data), .p0_read_ack(p0_read_ack),
    .p1_write_req(p1_write_req), .p1_write_addr(p1_write_addr), .p1_write_data(p1_write_data),
    .p1_write_ack(p1_write_ack), .p1_read_req(p1_read_req), .p1_read_addr(p1_read_addr),
    .p1_read_data(p1_read_data), .p1_read_ack(p1_read_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  mem_arbiter #(.WIDTH(W), .FAIR(0)) dut_f (
    .clk(clk), .reset(reset),
    .p0_write_req(1'b0), .p0_write_addr(32'h0), .p0_write_data({W{1'b0}}),
    .p0_write_ack(f_p0_wack), .p0_read_req(f_p0_rreq), .p0_read_addr(32'h200),
    .p0_read_data(f_p0_rdata), .p0_read_ack(f_p0_rack),
    .p1_write_req(1'b0), .p1_write_addr(32'h0), .p1_write_data({W{1'b0}}),
    .p1_write_ack(f_p1_wack), .p1_read_req(f_p1_rreq), .p1_read_addr(32'h300),
    .p1_read_data(f_p1_rdata), .p1_read_ack(f_p1_rack),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata), .mem_ack(f_mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 64'hA5A5_A5A5_A5A5_A5A5;
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [W-1:0] d);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    exp_mem.push_back(e);
  endtask

  task automatic push_ack(input int p, input logic op, input logic [W-1:0] d);
    ack_exp_t e;
    e.port = p; e.op = op; e.data = d;
    exp_ack.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 300 && !(exp_mem.size() == 0 && exp_ack.size() == 0 && !mem_req &&
           !p0_write_req && !p0_read_req && !p1_write_req && !p1_read_req &&
           rearm0 == 0 && rearm1 == 0 && !pend0 && !pend1)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completed_in_budget"}, 64'(n < 300), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Memory model for the main instance.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && mem_req && !reset) begin
        repeat (mem_lat) @(posedge clk);
        #1 mem_ack = 1'b1;
        mem_rdata = mem_model(mem_addr);
        @(posedge clk);
        #1 mem_ack = 1'b0;
      end
    end
  end

  // Memory model for the FAIR=0 instance (1-cycle).
  initial begin
    f_mem_ack = 1'b0;
    f_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (f_mem_req && !reset) begin
        @(posedge clk);
        #1 f_mem_ack = 1'b1;
        f_mem_rdata = mem_model(f_mem_addr);
        @(posedge clk);
        #1 f_mem_ack = 1'b0;
      end
    end
  end

  // Requester behaviour: drop req on ack, optionally re-raise one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pend0) begin pend0 = 0; p0_read_req = 1'b1; end
      if (pend1) begin pend1 = 0; p1_read_req = 1'b1; end
      if (pend_f1) begin pend_f1 = 0; f_p1_rreq = 1'b1; end
      if (p0_write_ack) p0_write_req = 1'b0;
      if (p1_write_ack) p1_write_req = 1'b0;
      if (p0_read_ack) begin
        p0_read_req = 1'b0;
        if (rearm0 > 0) begin rearm0--; pend0 = 1; end
      end
      if (p1_read_ack) begin
        p1_read_req = 1'b0;
        if (rearm1 > 0) begin rearm1--; pend1 = 1; end
      end
      if (f_p0_rack) f_p0_rreq = 1'b0;
      if (f_p1_rack) begin
        f_p1_rreq = 1'b0;
        if (rearm_f1 > 0) begin rearm_f1--; pend_f1 = 1; end
      end
    end
  end

  // Memory-side monitor: new transaction pops the queue; held ones must be stable.
  initial begin
    logic prev = 1'b0;
    mem_exp_t cap;
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_req && !prev) begin
        mem_txn++;
        check("mem_txn_expected", 64'(exp_mem.size() != 0), 64'd1);
        if (exp_mem.size() != 0) begin
          e = exp_mem.pop_front();
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          check("mem_wdata", mem_wdata, e.wdata);
        end
        cap.we = mem_we; cap.addr = mem_addr; cap.wdata = mem_wdata;
      end else if (!reset && mem_req) begin
        check("mem_held_stable", {mem_wdata ^ cap.wdata} | 64'(mem_addr ^ cap.addr) | 64'(mem_we ^ cap.we), 64'd0);
      end
      prev = mem_req;
    end
  end

  // Port-side monitor: at most one ack at a time, each one cycle wide, in order.
  initial begin
    logic prev_ack = 1'b0;
    int nack;
    int port;
    logic op;
    logic [W-1:0] data;
    ack_exp_t e;
    forever begin
      @(negedge clk);
      nack = int'(p0_write_ack) + int'(p0_read_ack) + int'(p1_write_ack) + int'(p1_read_ack);
      if (!reset && nack != 0) begin
        check("ack_one_at_a_time", 64'(nack), 64'd1);
        check("ack_single_cycle", 64'(prev_ack), 64'd0);
        port = (p1_write_ack || p1_read_ack) ? 1 : 0;
        op   = (p0_write_ack || p1_write_ack) ? 1'b1 : 1'b0;
        data = port ? p1_read_data : p0_read_data;
        check("ack_expected", 64'(exp_ack.size() != 0), 64'd1);
        if (exp_ack.size() != 0) begin
          e = exp_ack.pop_front();
          check("ack_port", 64'(port), 64'(e.port));
          check("ack_op", 64'(op), 64'(e.op));
          if (!op) check("ack_read_data", data, e.data);
        end
      end
      prev_ack = (nack != 0);
    end
  end

  // Monitor for the FAIR=0 instance.
  initial begin
    logic prev = 1'b0;
    logic [31:0] a;
    ack_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && f_mem_req && !prev) begin
        check("f0_mem_expected", 64'(exp_faddr.size() != 0), 64'd1);
        if (exp_faddr.size() != 0) begin
          a = exp_faddr.pop_front();
          check("f0_mem_addr", 64'(f_mem_addr), 64'(a));
        end
      end
      prev = f_mem_req;
      if (!reset && (f_p0_rack || f_p1_rack)) begin
        check("f0_ack_expected", 64'(exp_fack.size() != 0), 64'd1);
        if (exp_fack.size() != 0) begin
          e = exp_fack.pop_front();
          check("f0_ack_port", 64'(f_p1_rack ? 1 : 0), 64'(e.port));
          check("f0_ack_data", f_p1_rack ? f_p1_rdata : f_p0_rdata, e.data);
        end
      end
    end
  end

  initial begin
    ack_exp_t fe;
    int cnt0;
    reset = 1'b1;
    p0_write_req = 0; p0_read_req = 0; p1_write_req = 0; p1_read_req = 0;
    p0_write_addr = 0; p0_read_addr = 0; p1_write_addr = 0; p1_read_addr = 0;
    p0_write_data = 0; p1_write_data = 0;
    // FAIR=0: both held from reset, p1 re-raises once -> p1, p1, p0.
    f_p0_rreq = 1'b1; f_p1_rreq = 1'b1; rearm_f1 = 1;
    exp_faddr.push_back(32'h300); exp_faddr.push_back(32'h300); exp_faddr.push_back(32'h200);
    fe.op = 1'b0;
    fe.port = 1; fe.data = 64'hFFFF_FCFF_0000_0300; exp_fack.push_back(fe); exp_fack.push_back(fe);
    fe.port = 0; fe.data = 64'hFFFF_FDFF_0000_0200; exp_fack.push_back(fe);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_outputs", 64'({mem_we, p0_write_ack, p0_read_ack, p1_write_ack, p1_read_ack}), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    check("reset_read_data", p0_read_data | p1_read_data | mem_wdata, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single p0 read.
    push_mem(1'b0, 32'h100, 64'd0);
    push_ack(0, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
    p0_read_addr = 32'h100; p0_read_req = 1'b1;
    wait_idle("t1");
    check("t1_p0_read_data_held", p0_read_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t1_p1_read_data", p1_read_data, 64'd0);

    // 2: p1 write and read together; write first.
    push_mem(1'b1, 32'h40, 64'hDEAD_BEEF_DEAD_BEEF);
    push_ack(1, 1'b1, 64'd0);
    push_mem(1'b0, 32'h80, 64'd0);
    push_ack(1, 1'b0, 64'hFFFF_FF7F_0000_0080);
    @(posedge clk); #1;
    p1_write_addr = 32'h40; p1_write_data = 64'hDEAD_BEEF_DEAD_BEEF; p1_read_addr = 32'h80;
    p1_write_req = 1'b1; p1_read_req = 1'b1;
    wait_idle("t2");
    check("t2_p0_read_data_undisturbed", p0_read_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t2_p1_read_data", p1_read_data, 64'hFFFF_FF7F_0000_0080);

    // 3: both reads held from reset, FAIR=1 -> p0, p1, p0, p1.
    @(posedge clk); #1;
    reset = 1'b1;
    p0_read_addr = 32'h200; p1_read_addr = 32'h300;
    p0_read_req = 1'b1; p1_read_req = 1'b1; rearm0 = 1; rearm1 = 1;
    for (int i = 0; i < 2; i++) begin
      push_mem(1'b0, 32'h200, 64'd0); push_ack(0, 1'b0, 64'hFFFF_FDFF_0000_0200);
      push_mem(1'b0, 32'h300, 64'd0); push_ack(1, 1'b0, 64'hFFFF_FCFF_0000_0300);
    end
    @(posedge clk); #1 reset = 1'b0;
    wait_idle("t3");

    // 4: p0 re-raises read the cycle after its ack; exactly two transactions.
    cnt0 = mem_txn;
    for (int i = 0; i < 2; i++) begin
      push_mem(1'b0, 32'h500, 64'd0); push_ack(0, 1'b0, 64'hFFFF_FAFF_0000_0500);
    end
    @(posedge clk); #1;
    p0_read_addr = 32'h500; rearm0 = 1; p0_read_req = 1'b1;
    wait_idle("t4");
    check("t4_mem_txn_count", 64'(mem_txn - cnt0), 64'd2);

    // 5: reset during BUSY, then a stray mem_ack.
    mem_auto = 0;
    push_mem(1'b0, 32'h700, 64'd0);
    @(posedge clk); #1;
    p0_read_addr = 32'h700; p0_read_req = 1'b1;
    begin
      int n = 0;
      while (!mem_req && n < 20) begin @(negedge clk); n++; end
      check("t5_mem_req_seen", 64'(mem_req), 64'd1);
    end
    @(posedge clk); #1 reset = 1'b1; p0_read_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("t5_after_reset_mem", 64'({mem_req, mem_we}) | 64'(mem_addr) | mem_wdata, 64'd0);
    check("t5_after_reset_read_data", p0_read_data | p1_read_data, 64'd0);
    check("t5_after_reset_acks", 64'({p0_write_ack, p0_read_ack, p1_write_ack, p1_read_ack}), 64'd0);
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    @(posedge clk); #1 mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_stray_ack_read_data", p0_read_data | p1_read_data, 64'd0);
    check("t5_stray_ack_mem_req", 64'(mem_req), 64'd0);
    mem_auto = 1;
    push_mem(1'b0, 32'h100, 64'd0);
    push_ack(0, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
    @(posedge clk); #1;
    p0_read_addr = 32'h100; p0_read_req = 1'b1;
    wait_idle("t5");

    // 6: spurious mem_ack in IDLE.
    mem_auto = 0;
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(posedge clk); #1 mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_p0_read_data", p0_read_data, 64'hA5A5_A5A5_A5A5_A5A5);
    check("t6_p1_read_data", p1_read_data, 64'd0);
    check("t6_mem_req", 64'(mem_req), 64'd0);

    check("f0_all_mem_seen", 64'(exp_faddr.size()), 64'd0);
    check("f0_all_acks_seen", 64'(exp_fack.size()), 64'd0);
    check("main_queues_empty", 64'(exp_mem.size() + exp_ack.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
